// File: rtl/bios_fetch.sv
// BIOS ROM instruction fetch: sequential/redirected address issue, 1-cycle ROM pairing, 1-entry skid.
// Optional fetch-fault tracking (misaligned / out-of-window) is enabled by defining BIOS_FETCH_FAULT_EN.
module bios_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned ROM_BYTES    = 4096
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        jmp_valid_i,
    input  logic [31:0] jmp_addr_i,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_data_i,
    output logic        if_valid_o,
    input  logic        if_ready_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_ir_o
`ifdef BIOS_FETCH_FAULT_EN
    ,
    output logic        if_fault_o
`endif
);

    typedef logic [31:0] word_t;

    function automatic logic addr_fault(input word_t a);
        return (a[1:0] != 2'b00) || (a >= word_t'(ROM_BYTES));
    endfunction

    word_t next_pc_q;
    logic  req_valid_q;
    word_t req_pc_q;
    logic  skid_valid_q;
    word_t skid_pc_q;
    word_t skid_ir_q;
`ifdef BIOS_FETCH_FAULT_EN
    logic  req_fault_q;
    logic  skid_fault_q;
`endif

    logic  issue;
    logic  capture;
    word_t issue_addr;

    // An idle pipe always issues, so the skid and the in-flight slot can never both be full.
    assign issue      = jmp_valid_i || if_ready_i || (!skid_valid_q && !req_valid_q);
    assign capture    = req_valid_q && !skid_valid_q && !if_ready_i && !jmp_valid_i;
    assign issue_addr = jmp_valid_i ? jmp_addr_i : next_pc_q;
    assign rom_addr_o = issue_addr;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            next_pc_q    <= RESET_VECTOR;
            req_valid_q  <= 1'b0;
            req_pc_q     <= '0;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= '0;
            skid_ir_q    <= '0;
`ifdef BIOS_FETCH_FAULT_EN
            req_fault_q  <= 1'b0;
            skid_fault_q <= 1'b0;
`endif
        end else begin
            if (issue) begin
                req_valid_q <= 1'b1;
                req_pc_q    <= issue_addr;
                next_pc_q   <= issue_addr + 32'd4;
`ifdef BIOS_FETCH_FAULT_EN
                req_fault_q <= addr_fault(issue_addr);
`endif
            end else begin
                req_valid_q <= 1'b0;
            end

            // A redirect discards whatever the skid holds.
            if (jmp_valid_i) begin
                skid_valid_q <= 1'b0;
            end else if (capture) begin
                skid_valid_q <= 1'b1;
                skid_pc_q    <= req_pc_q;
                skid_ir_q    <= rom_data_i;
`ifdef BIOS_FETCH_FAULT_EN
                skid_fault_q <= req_fault_q;
`endif
            end else if (skid_valid_q && if_ready_i) begin
                skid_valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        if_valid_o = 1'b0;
        if_pc_o    = '0;
        if_ir_o    = '0;
`ifdef BIOS_FETCH_FAULT_EN
        if_fault_o = 1'b0;
`endif
        if (!jmp_valid_i) begin
            if (skid_valid_q) begin
                if_valid_o = 1'b1;
                if_pc_o    = skid_pc_q;
                if_ir_o    = skid_ir_q;
`ifdef BIOS_FETCH_FAULT_EN
                if_fault_o = skid_fault_q;
`endif
            end else if (req_valid_q) begin
                if_valid_o = 1'b1;
                if_pc_o    = req_pc_q;
                if_ir_o    = rom_data_i;
`ifdef BIOS_FETCH_FAULT_EN
                if_fault_o = req_fault_q;
`endif
            end
        end
`ifdef BIOS_FETCH_FAULT_EN
        // Faulting fetches never expose ROM data.
        if (if_fault_o) begin
            if_ir_o = '0;
        end
`endif
    end

endmodule
